// File: rtl/irq_ctrl_if.sv
// CPU-facing port of the interrupt controller: the req/ack handshake and the
// memory-mapped register bus. The controller uses the slave modport.
interface irq_ctrl_if #(
    parameter int ID_W = 5
);
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic [3:0]      reg_addr;
    logic            reg_we;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;

    modport master (
        input  irq_req, irq_id, reg_rdata,
        output irq_ack, reg_addr, reg_we, reg_wdata
    );

    modport slave (
        output irq_req, irq_id, reg_rdata,
        input  irq_ack, reg_addr, reg_we, reg_wdata
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, software enable mask,
// fixed lowest-index-wins priority and a req/ack/EOI handshake with the CPU.
module irq_ctrl #(
    parameter int NUM_IRQ = 2,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    irq_ctrl_if.slave          bus
);
    localparam logic [3:0] ADDR_PENDING = 4'h0;
    localparam logic [3:0] ADDR_ENABLE  = 4'h4;
    localparam logic [3:0] ADDR_STATUS  = 4'h8;
    localparam logic [3:0] ADDR_EOI     = 4'hC;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state_reg, state_next;
    logic [NUM_IRQ-1:0] src_q_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] enable_reg, enable_next;
    logic [NUM_IRQ-1:0] set_vec, ack_clr, w1c_clr, cand;
    logic               irq_req_reg, irq_req_next;
    logic [ID_W-1:0]    irq_id_reg, irq_id_next;
    logic [ID_W-1:0]    in_service_reg, in_service_next;
    logic [ID_W-1:0]    winner;
    logic [31:0]        rdata_reg, rdata_next;
    logic               ack_fire, eoi_wr, pend_wr, en_wr;

    assign set_vec  = irq_src & ~src_q_reg;
    assign cand     = pending_reg & enable_reg;
    assign ack_fire = (state_reg == REQ) && bus.irq_ack;
    assign eoi_wr   = bus.reg_we && (bus.reg_addr == ADDR_EOI);
    assign pend_wr  = bus.reg_we && (bus.reg_addr == ADDR_PENDING);
    assign en_wr    = bus.reg_we && (bus.reg_addr == ADDR_ENABLE);

    // Per-source bookkeeping; a fresh edge always wins over both clear paths
    // so that no event is lost.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            assign ack_clr[gi]      = ack_fire && (irq_id_reg == ID_W'(gi));
            assign w1c_clr[gi]      = pend_wr && bus.reg_wdata[gi];
            assign pending_next[gi] = set_vec[gi] |
                                      (pending_reg[gi] & ~ack_clr[gi] & ~w1c_clr[gi]);
            assign enable_next[gi]  = en_wr ? bus.reg_wdata[gi] : enable_reg[gi];
        end
    endgenerate

    // Descending scan so the lowest set index is the last assignment.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        irq_req_next    = irq_req_reg;
        irq_id_next     = irq_id_reg;
        in_service_next = in_service_reg;
        case (state_reg)
            IDLE: begin
                if (cand != '0) begin
                    irq_req_next = 1'b1;
                    irq_id_next  = winner;
                    state_next   = REQ;
                end
            end
            REQ: begin
                // Request stays frozen until the CPU accepts it.
                if (bus.irq_ack) begin
                    irq_req_next    = 1'b0;
                    in_service_next = irq_id_reg;
                    state_next      = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi_wr) begin
                    in_service_next = '0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                irq_req_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        rdata_next = '0;
        case (bus.reg_addr)
            ADDR_PENDING: rdata_next[NUM_IRQ-1:0] = pending_reg;
            ADDR_ENABLE:  rdata_next[NUM_IRQ-1:0] = enable_reg;
            ADDR_STATUS: begin
                rdata_next[ID_W+1:2] = in_service_reg;
                rdata_next[1]        = (state_reg == SERVICE);
                rdata_next[0]        = irq_req_reg;
            end
            default:      rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            src_q_reg      <= '0;
            pending_reg    <= '0;
            enable_reg     <= '0;
            irq_req_reg    <= 1'b0;
            irq_id_reg     <= '0;
            in_service_reg <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            src_q_reg      <= irq_src;
            pending_reg    <= pending_next;
            enable_reg     <= enable_next;
            irq_req_reg    <= irq_req_next;
            irq_id_reg     <= irq_id_next;
            in_service_reg <= in_service_next;
            rdata_reg      <= rdata_next;
        end
    end

    assign bus.irq_req   = irq_req_reg;
    assign bus.irq_id    = irq_id_reg;
    assign bus.reg_rdata = rdata_reg;
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a table of enable/source patterns plus hand-written
// handshake, priority, mask, collision and reset sequences.
module tb_irq_ctrl;
    localparam int NUM_IRQ = 2;
    localparam int ID_W    = 5;

    logic               CLOCK_50 = 1'b0;
    logic               rst      = 1'b1;
    logic [NUM_IRQ-1:0] irq_src  = '0;

    irq_ctrl_if #(.ID_W(ID_W)) bus ();

    irq_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
        .clk     (CLOCK_50),
        .rst     (rst),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [1:0] en;
        logic [1:0] src;
        logic       exp_req;
        logic [4:0] exp_id;
        logic [1:0] exp_pend;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[7];
    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Read: expectation queued when the address is driven, compared when
    // the registered read data appears one edge later.
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
        sb_t ent;
        bus.reg_addr = a;
        bus.reg_we   = 1'b0;
        sb_q.push_back('{nm, exp});
        tick();
        ent = sb_q.pop_front();
        check(ent.name, bus.reg_rdata, ent.exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_we    = 1'b1;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] s);
        irq_src = s;
        tick();
        irq_src = '0;
    endtask

    task automatic check_req(input string nm, input logic exp_req, input logic [4:0] exp_id);
        check({nm, ".req"}, 32'(bus.irq_req), 32'(exp_req));
        if (exp_req) check({nm, ".id"}, 32'(bus.irq_id), 32'(exp_id));
    endtask

    task automatic do_reset(input bit check_out);
        irq_src       = '0;
        bus.irq_ack   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = 4'h0;
        bus.reg_wdata = '0;
        rst           = 1'b1;
        tick();
        if (check_out) begin
            check("reset.req",   32'(bus.irq_req), 32'd0);
            check("reset.id",    32'(bus.irq_id),  32'd0);
            check("reset.rdata", bus.reg_rdata,    32'd0);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            en     src    req   id     pend
        vecs[0] = '{2'b11, 2'b10, 1'b1, 5'd1, 2'b10};
        vecs[1] = '{2'b11, 2'b01, 1'b1, 5'd0, 2'b01};
        vecs[2] = '{2'b11, 2'b11, 1'b1, 5'd0, 2'b11};
        vecs[3] = '{2'b01, 2'b10, 1'b0, 5'd0, 2'b10};
        vecs[4] = '{2'b10, 2'b11, 1'b1, 5'd1, 2'b11};
        vecs[5] = '{2'b00, 2'b11, 1'b0, 5'd0, 2'b11};
        vecs[6] = '{2'b10, 2'b01, 1'b0, 5'd0, 2'b01};

        bus.irq_ack   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = 4'h0;
        bus.reg_wdata = '0;

        do_reset(1'b1);
        rd(4'h4, 32'h0, "reset.enable");
        rd(4'h8, 32'h0, "reset.status");

        for (int i = 0; i < 7; i++) begin
            do_reset(1'b0);
            wr(4'h4, 32'(vecs[i].en));
            pulse(vecs[i].src);
            check($sformatf("vec%0d.early_req", i), 32'(bus.irq_req), 32'd0);
            tick();
            check_req($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_id);
            rd(4'h0, 32'(vecs[i].exp_pend), $sformatf("vec%0d.pending", i));
            rd(4'h4, 32'(vecs[i].en), $sformatf("vec%0d.enable", i));
        end

        // Basic handshake, request held stable while ENABLE is cleared
        do_reset(1'b0);
        wr(4'h4, 32'h3);
        pulse(2'b10);
        tick();
        check_req("basic", 1'b1, 5'd1);
        wr(4'h4, 32'h0);
        check_req("basic.hold", 1'b1, 5'd1);
        wr(4'h4, 32'h3);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("basic.ack_req", 32'(bus.irq_req), 32'd0);
        rd(4'h0, 32'h0, "basic.pending");
        rd(4'h8, 32'h6, "basic.status_svc");
        wr(4'hC, 32'h0);
        rd(4'h8, 32'h0, "basic.status_eoi");

        // Priority: timer first, keyboard exactly one cycle after IDLE entry
        do_reset(1'b0);
        wr(4'h4, 32'h3);
        pulse(2'b11);
        tick();
        check_req("prio.first", 1'b1, 5'd0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("prio.ack_req", 32'(bus.irq_req), 32'd0);
        wr(4'hC, 32'h0);
        check("prio.idle_req", 32'(bus.irq_req), 32'd0);
        tick();
        check_req("prio.second", 1'b1, 5'd1);

        // Mask then unmask
        do_reset(1'b0);
        wr(4'h4, 32'h1);
        pulse(2'b10);
        tick();
        check("mask.req", 32'(bus.irq_req), 32'd0);
        rd(4'h0, 32'h2, "mask.pending");
        wr(4'h4, 32'h3);
        check("mask.wr_req", 32'(bus.irq_req), 32'd0);
        tick();
        check_req("mask.unmask", 1'b1, 5'd1);

        // Collisions: new edge beats ack-clear and W1C
        do_reset(1'b0);
        wr(4'h4, 32'h1);
        pulse(2'b01);
        tick();
        check_req("coll.req", 1'b1, 5'd0);
        bus.irq_ack = 1'b1;
        irq_src     = 2'b01;
        tick();
        bus.irq_ack = 1'b0;
        irq_src     = '0;
        check("coll.ack_req", 32'(bus.irq_req), 32'd0);
        rd(4'h0, 32'h1, "coll.ack_pending");
        irq_src = 2'b01;
        wr(4'h0, 32'h1);
        irq_src = '0;
        rd(4'h0, 32'h1, "coll.w1c_pending");
        wr(4'h0, 32'h1);
        rd(4'h0, 32'h0, "coll.w1c_clear");
        check("coll.svc_req", 32'(bus.irq_req), 32'd0);

        // Level held high sets pending only once
        do_reset(1'b0);
        irq_src = 2'b01;
        tick();
        wr(4'h0, 32'h1);
        tick();
        tick();
        rd(4'h0, 32'h0, "level.pending");
        irq_src = '0;

        // Asynchronous reset while requesting
        do_reset(1'b0);
        wr(4'h4, 32'h3);
        pulse(2'b01);
        tick();
        check_req("rstreq.req", 1'b1, 5'd0);
        rst = 1'b1;
        #1;
        check("rstreq.async_req", 32'(bus.irq_req), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("rstreq.after_req", 32'(bus.irq_req), 32'd0);
        rd(4'h0, 32'h0, "rstreq.pending");
        rd(4'h4, 32'h0, "rstreq.enable");
        wr(4'h4, 32'h1);
        pulse(2'b01);
        tick();
        check_req("rstreq.new_edge", 1'b1, 5'd0);
        rd(4'h8, 32'h1, "rstreq.status_req");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
